// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV/RVC immediate generator behind a 2-entry valid/ready skid buffer
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [3:0]       imm_gen_op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_rvc_op;
  logic             w_acc;
  logic             w_out_free;
  logic             w_unused;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;
  logic             r_skd_valid;
  logic [XLEN-1:0]  r_skd_imm;
  logic [TAG_W-1:0] r_skd_tag;
  logic             r_skd_ill;
  assign w_unused   = &{1'b0, inst_i[1:0]};
  assign w_rvc_op   = imm_gen_op_i >= 4'd9 && imm_gen_op_i <= 4'd12;
  assign w_acc      = in_valid_i && !r_skd_valid;
  assign w_out_free = !r_out_valid || out_ready_i;
  // decode and extend the immediate for the selected format; compressed ops collapse to illegal when RVC is off
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (imm_gen_op_i)
      4'd0:    w_imm = '0;
      4'd1:    w_imm = XLEN'($signed(inst_i[31:20]));
      4'd2:    w_imm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      4'd3:    w_imm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      4'd4:    w_imm = XLEN'($signed({inst_i[31:12], 12'b0}));
      4'd5:    w_imm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
      4'd6:    w_imm = XLEN'(inst_i[19:15]);
      4'd7:    w_imm = XLEN'(inst_i[19:15]);
      4'd8:    w_imm = ~XLEN'(inst_i[19:15]);
      4'd9:    w_imm = XLEN'($signed({inst_i[12], inst_i[6:2]}));
      4'd10:   w_imm = XLEN'($signed({inst_i[12], inst_i[8], inst_i[10:9], inst_i[6], inst_i[7],
                                      inst_i[2], inst_i[11], inst_i[5:3], 1'b0}));
      4'd11:   w_imm = XLEN'($signed({inst_i[12], inst_i[6:5], inst_i[2], inst_i[11:10], inst_i[4:3], 1'b0}));
      4'd12:   w_imm = XLEN'({inst_i[10:7], inst_i[12:11], inst_i[5], inst_i[6], 2'b0});
      default: w_ill = 1'b1;
    endcase
    if (w_rvc_op && !RVC_EN) begin
      w_imm = '0;
      w_ill = 1'b1;
    end
  end
  // stage valids: flush beats everything, a free output stage pulls from skid first, else the new beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_skd_valid <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
      r_skd_valid <= 1'b0;
    end else if (w_out_free) begin
      r_out_valid <= r_skd_valid || w_acc;
      r_skd_valid <= 1'b0;
    end else if (w_acc) begin
      r_skd_valid <= 1'b1;
    end
  end
  // stage payloads: output register only changes when free, so a stalled beat holds stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_imm <= '0;
      r_out_tag <= '0;
      r_out_ill <= 1'b0;
      r_skd_imm <= '0;
      r_skd_tag <= '0;
      r_skd_ill <= 1'b0;
    end else begin
      if (w_out_free && r_skd_valid) begin
        r_out_imm <= r_skd_imm;
        r_out_tag <= r_skd_tag;
        r_out_ill <= r_skd_ill;
      end else if (w_out_free && w_acc) begin
        r_out_imm <= w_imm;
        r_out_tag <= tag_i;
        r_out_ill <= w_ill;
      end
      if (!w_out_free && w_acc) begin
        r_skd_imm <= w_imm;
        r_skd_tag <= tag_i;
        r_skd_ill <= w_ill;
      end
    end
  end
  assign in_ready_o  = !r_skd_valid;
  assign out_valid_o = r_out_valid;
  assign imm_o       = r_out_imm;
  assign tag_o       = r_out_tag;
  assign illegal_o   = r_out_ill;
endmodule
